// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack handshake and
// hands one instruction at a time to the control unit and datapath.
// Optional retired-instruction counter: define FETCH_INSTRET_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        instr_valid,
  output logic        misalign_err,
  output logic [31:0] instret
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {IDLE, REQ, VALID, ERR} state_t;

  state_t state;
  logic   retire;
  logic   bad_target;

  // Retire happens on any unstalled edge in VALID; a misaligned taken target traps.
  assign retire     = (state == VALID) && !stall;
  assign bad_target = PCSrc && (PCTarget[1:0] != 2'b00);
  assign PCPlus4    = PC + XLEN'(4);
  assign imem_addr  = PC;

  // Fetch FSM with registered handshake, instruction and PC outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      PC           <= RESET_PC;
      Instr        <= NOP_INSTR;
      instr_valid  <= 1'b0;
      imem_req     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          imem_req <= 1'b1;
          state    <= REQ;
        end
        REQ: begin
          if (imem_ack) begin
            Instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= VALID;
          end
        end
        VALID: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            Instr       <= NOP_INSTR;
            if (bad_target) begin
              misalign_err <= 1'b1;
              state        <= ERR;
            end else begin
              PC       <= PCSrc ? PCTarget : PCPlus4;
              imem_req <= 1'b1;
              state    <= REQ;
            end
          end
        end
        ERR: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_INSTRET_EN
  // Count every retire edge, including the one that traps on a bad target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + XLEN'(1);
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign instret       = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// fetch/stall/branch traffic checked against a transaction-level PC model.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_valid;
  logic        misalign_err;
  logic [31:0] instret;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ret;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .PCTarget(PCTarget), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
    .instr_valid(instr_valid), .misalign_err(misalign_err), .instret(instret)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_ret();
`ifdef FETCH_INSTRET_EN
    return m_ret;
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'hA000_0000;
  endfunction

  // Wait (bounded) for a request, then check its address.
  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", 32'(imem_req), 32'h1);
    check("req_addr", imem_addr, m_pc);
    check("req_pc", PC, m_pc);
    check("req_pcplus4", PCPlus4, m_pc + 32'd4);
    check("req_valid", 32'(instr_valid), 32'h0);
  endtask

  // One complete fetch: ack after dly cycles, hold stl cycles, then retire.
  task automatic fetch(input int dly, input int stl, input logic src, input logic [31:0] tgt);
    logic [31:0] w;
    w = mem_word(m_pc);
    wait_req();
    for (int i = 0; i < dly; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      check("wait_req", 32'(imem_req), 32'h1);
      check("wait_addr", imem_addr, m_pc);
      check("wait_valid", 32'(instr_valid), 32'h0);
      check("wait_instr", Instr, NOP);
    end
    imem_ack   = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("cap_valid", 32'(instr_valid), 32'h1);
    check("cap_instr", Instr, w);
    check("cap_req", 32'(imem_req), 32'h0);
    check("cap_pc", PC, m_pc);
    check("cap_instret", instret, exp_ret());
    for (int i = 0; i < stl; i++) begin
      stall      = 1'b1;
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clk);
      check("stall_valid", 32'(instr_valid), 32'h1);
      check("stall_instr", Instr, w);
      check("stall_pc", PC, m_pc);
      check("stall_req", 32'(imem_req), 32'h0);
      check("stall_instret", instret, exp_ret());
    end
    stall    = 1'b0;
    imem_ack = 1'b0;
    PCSrc    = src;
    PCTarget = tgt;
    @(negedge clk);
    PCSrc    = 1'b0;
    PCTarget = $urandom;
    m_ret    = m_ret + 32'd1;
    if (src && (tgt[1:0] != 2'b00)) begin
      check("err_flag", 32'(misalign_err), 32'h1);
      check("err_pc", PC, m_pc);
      check("err_req", 32'(imem_req), 32'h0);
      check("err_valid", 32'(instr_valid), 32'h0);
    end else begin
      m_pc = src ? tgt : m_pc + 32'd4;
      check("ret_pc", PC, m_pc);
      check("ret_valid", 32'(instr_valid), 32'h0);
      check("ret_instr", Instr, NOP);
      check("ret_req", 32'(imem_req), 32'h1);
      check("ret_misalign", 32'(misalign_err), 32'h0);
    end
    check("ret_instret", instret, exp_ret());
  endtask

  initial begin
    rst_n = 1'b0; PCSrc = 1'b0; PCTarget = '0; stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    m_pc = 32'h0; m_ret = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_pc", PC, 32'h0);
    check("rst_instr", Instr, NOP);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_misalign", 32'(misalign_err), 32'h0);
    check("rst_instret", instret, 32'h0);

    // One dead cycle after release, then the first request
    rst_n = 1'b1;
    #1 check("idle_req", 32'(imem_req), 32'h0);
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'h1);

    // Sequential fetches; third one branches from 0x8 to 0x40
    fetch(0, 0, 1'b0, 32'h0);
    fetch(0, 0, 1'b0, 32'h0);
    fetch(0, 0, 1'b1, 32'h40);
    check("branch_addr", imem_addr, 32'h40);
    check("branch_plus4", PCPlus4, 32'h44);

    // Long stall, delayed ack with spurious acks while valid
    fetch(0, 5, 1'b0, 32'h0);
    fetch(3, 2, 1'b0, 32'h0);

    // Randomized traffic with aligned branches
    for (int k = 0; k < 16; k++) begin
      fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), 32'($urandom_range(0, 255)) << 2);
    end

    // Misaligned taken target traps until reset
    fetch(0, 0, 1'b1, 32'h42);
    for (int i = 0; i < 5; i++) begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clk);
      check("trap_req", 32'(imem_req), 32'h0);
      check("trap_flag", 32'(misalign_err), 32'h1);
      check("trap_pc", PC, m_pc);
      check("trap_valid", 32'(instr_valid), 32'h0);
    end
    imem_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    check("trap_rst_flag", 32'(misalign_err), 32'h0);
    check("trap_rst_pc", PC, 32'h0);
    m_pc = 32'h0; m_ret = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    fetch(0, 0, 1'b0, 32'h0);

    // PC wrap from 0xFFFFFFFC to 0
    fetch(1, 0, 1'b1, 32'hFFFF_FFFC);
    fetch(0, 1, 1'b0, 32'h0);
    check("wrap_pc", PC, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    // Reset during a pending request; late ack ignored in IDLE
    check("pend_req", 32'(imem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    check("pend_rst_req", 32'(imem_req), 32'h0);
    m_pc = 32'h0; m_ret = 32'h0;
    @(negedge clk);
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    check("late_ack_req", 32'(imem_req), 32'h1);
    check("late_ack_valid", 32'(instr_valid), 32'h0);
    check("late_ack_instr", Instr, NOP);
    fetch(0, 0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream fetch stage of the single-cycle RISC-V core.
- Owns the program counter and fetches each 32-bit instruction from instruction memory over a req/ack handshake.
- Presents `Instr` and `PC` to the control unit and datapath.
- Advances the PC to PC+4, or to the branch target when the control unit asserts `PCSrc`.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on `Instr` while no valid instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- PCSrc  input  1  from control unit; 1 = next PC is PCTarget.
- PCTarget  input  32  branch/jump target from the datapath adder.
- stall  input  1  downstream hold; 1 = keep the current instruction.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equal to PC.
- imem_ack  input  1  memory ack; imem_rdata is valid in the same cycle.
- imem_rdata  input  32  fetched instruction word.
- Instr  output  32  registered instruction to the control unit and datapath.
- PC  output  32  current program counter.
- PCPlus4  output  32  PC + 4, combinational, modulo 2^32.
- instr_valid  output  1  Instr/PC hold a fetched, not-yet-consumed instruction.
- misalign_err  output  1  sticky; a taken target had bits [1:0] != 0.
- instret  output  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (asynchronous assert, synchronous release) sets:
  - PC = RESET_PC, Instr = NOP_INSTR.
  - instr_valid = 0, imem_req = 0, misalign_err = 0, instret = 0.
  - state = IDLE.
- FSM states: IDLE, REQ, VALID, ERR.
  - IDLE: imem_req = 0. Moves to REQ on the next edge (one dead cycle after reset release).
  - REQ: imem_req = 1 and imem_addr = PC, both held stable until ack.
    - On an edge with imem_ack = 1: Instr <= imem_rdata, instr_valid <= 1, go to VALID.
    - An ack in the same cycle that req first rises is legal; minimum fetch latency is 1 cycle.
  - VALID: imem_req = 0, instr_valid = 1.
    - stall = 1: hold PC, Instr and instr_valid unchanged.
    - stall = 0: the instruction retires on this edge:
      - PC <= PCSrc ? PCTarget : PCPlus4.
      - instr_valid <= 0, Instr <= NOP_INSTR, go to REQ.
    - PCSrc and PCTarget are sampled only at the retire edge.
  - ERR: entered instead of REQ when retiring with PCSrc = 1 and PCTarget[1:0] != 0.
    - PC is not updated; misalign_err <= 1.
    - imem_req = 0, instr_valid = 0.
    - ERR is left only by reset.
- imem_ack while imem_req = 0 is ignored; no state change.
- Steady-state throughput: one instruction per 2 cycles with zero-wait memory.
- PC wrap: PCPlus4 from 32'hFFFF_FFFC is 32'h0000_0000. No error is raised.
- Reset mid-fetch: imem_req drops immediately; an ack arriving later is ignored by the IDLE state.
- A PCTarget equal to PC (self-loop) is legal and re-fetches the same address.

Optional Feature:
- Macro: FETCH_INSTRET_EN.
- Defined: instret increments by 1 on every retire edge (VALID and stall = 0, including the misalign retire). It is 32-bit and wraps at 2^32, with reset value 0.
- Not defined: the counter logic is removed and instret is tied to 32'h0.

Test Plan:
1. Reset with RESET_PC = 0; memory acks in the same cycle, returning word = address | 32'hA000_0000; stall = 0, PCSrc = 0.
   - First imem_req appears 1 cycle after reset release.
   - Instr sequence A0000000, A0000004, A0000008, each valid for exactly 1 cycle.
   - instret = 3 after the third retire (macro defined).
2. At PC = 32'h8, assert PCSrc = 1 with PCTarget = 32'h40 on the retire edge.
   - Next imem_addr = 32'h40; PCPlus4 = 32'h44.
3. Hold stall = 1 for 5 cycles while VALID.
   - PC, Instr and instr_valid = 1 stay unchanged; imem_req stays 0; instret does not change.
   - Release stall: PC advances by 4 on the next edge.
4. Memory delays ack by 3 cycles.
   - imem_req and imem_addr stay stable for all 4 cycles.
   - Instr captures the data on the ack edge only.
   - A spurious ack while in VALID has no effect.
5. Retire with PCSrc = 1 and PCTarget = 32'h42.
   - misalign_err = 1, PC stays at the old value, imem_req stays 0 indefinitely.
   - rst_n low clears misalign_err and restarts from RESET_PC.
6. Set PC = 32'hFFFF_FFFC and retire with PCSrc = 0.
   - PC becomes 32'h0 and the next fetch goes to address 0.
   - Assert rst_n low during a pending REQ: imem_req drops asynchronously within the same cycle.
